// File: rtl/uart_gateway_pkg.sv
// Shared types and defaults for the UART gateway transmit path.
package uart_gateway_pkg;

   localparam int DEFAULT_DEPTH       = 16;
   localparam int DEFAULT_MAX_RETRIES = 2;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_ACK,
      WAIT_FREE
   } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO for the UART transmit queue: synchronous write, combinational head,
// pointers one bit wider than the address so full/empty fall out of the MSB compare.
module uart_tx_fifo
   import uart_gateway_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push_i,
   input  logic [7:0]               push_data_i,
   input  logic                     pop_i,
   output logic [7:0]               head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     overflow_o
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem_q [DEPTH];
   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   logic        overflow_q, overflow_d;
   logic        pop_ok, push_ok;

   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign level_o = wptr_q - rptr_q;
   assign head_o  = mem_q[rptr_q[AW-1:0]];

   // A pop in the same cycle frees the slot, so a push while full is still accepted.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      overflow_d = push_i && !push_ok;
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         overflow_q <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data_i;
   end

   assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_byte_queue.sv
// Queues bytes and hands them one at a time to the downstream write stage.
// Define UART_TX_QUEUE_RETRY_EN to re-issue a byte up to MAX_RETRIES times on ack timeout.
module uart_tx_byte_queue
   import uart_gateway_pkg::*;
#(
   parameter int DEPTH       = DEFAULT_DEPTH,
   parameter int MAX_RETRIES = DEFAULT_MAX_RETRIES
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push,
   input  logic [7:0]               push_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     write_enable,
   output logic [7:0]               write_data,
   input  logic                     write_ack,
   input  logic                     write_busy,
   input  logic                     write_ack_timeout,
   output logic                     overflow,
   output logic                     drop
);

   tx_state_e  state_q, state_d;
   logic [7:0] wdata_q, wdata_d;
   logic       drop_q, drop_d;
   logic       pop;
   logic [7:0] head;

`ifdef UART_TX_QUEUE_RETRY_EN
   localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
   logic [RW-1:0] retry_q, retry_d;
   logic          reissue_q, reissue_d;
`endif

   uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rstn        (rstn),
      .push_i      (push),
      .push_data_i (push_data),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (full),
      .empty_o     (empty),
      .level_o     (level),
      .overflow_o  (overflow)
   );

   always_comb begin
      state_d      = state_q;
      wdata_d      = wdata_q;
      drop_d       = 1'b0;
      pop          = 1'b0;
      write_enable = 1'b0;
`ifdef UART_TX_QUEUE_RETRY_EN
      retry_d      = retry_q;
      reissue_d    = reissue_q;
`endif
      case (state_q)
         IDLE: begin
            if (!empty && !write_busy) begin
               wdata_d = head;
               state_d = ISSUE;
            end
         end
         // Busy may rise after IDLE committed; hold the strobe until it drops.
         ISSUE: begin
            if (!write_busy) begin
               write_enable = 1'b1;
               state_d      = WAIT_ACK;
`ifdef UART_TX_QUEUE_RETRY_EN
               if (!reissue_q) retry_d = '0;
               reissue_d = 1'b0;
`endif
            end
         end
         WAIT_ACK: begin
            if (write_ack) begin
               pop     = 1'b1;
               state_d = WAIT_FREE;
            end else if (write_ack_timeout) begin
`ifdef UART_TX_QUEUE_RETRY_EN
               if (retry_q < RW'(MAX_RETRIES)) begin
                  retry_d   = retry_q + 1'b1;
                  reissue_d = 1'b1;
               end else begin
                  pop    = 1'b1;
                  drop_d = 1'b1;
               end
`else
               pop    = 1'b1;
               drop_d = 1'b1;
`endif
               state_d = WAIT_FREE;
            end
         end
         WAIT_FREE: begin
            if (!write_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         wdata_q   <= '0;
         drop_q    <= 1'b0;
`ifdef UART_TX_QUEUE_RETRY_EN
         retry_q   <= '0;
         reissue_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         wdata_q   <= wdata_d;
         drop_q    <= drop_d;
`ifdef UART_TX_QUEUE_RETRY_EN
         retry_q   <= retry_d;
         reissue_q <= reissue_d;
`endif
      end
   end

   assign write_data = wdata_q;
   assign drop       = drop_q;

endmodule

// File: tb/tb_uart_tx_byte_queue.sv
// Scoreboard bench for uart_tx_byte_queue: stimulus queues expected issued bytes,
// a monitor pops them on each write_enable, a responder models the downstream stage.
module tb_uart_tx_byte_queue;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       push = 1'b0;
   logic [7:0] push_data = 8'h00;
   logic       full, empty;
   logic [4:0] level;
   logic       write_enable;
   logic [7:0] write_data;
   logic       write_ack = 1'b0;
   logic       write_ack_timeout = 1'b0;
   logic       busy_force = 1'b0;
   logic       busy_resp = 1'b0;
   logic       write_busy;
   logic       overflow, drop;

   assign write_busy = busy_force | busy_resp;

   uart_tx_byte_queue #(.DEPTH(DEPTH), .MAX_RETRIES(2)) dut (
      .clk               (clk),
      .rstn              (rstn),
      .push              (push),
      .push_data         (push_data),
      .full              (full),
      .empty             (empty),
      .level             (level),
      .write_enable      (write_enable),
      .write_data        (write_data),
      .write_ack         (write_ack),
      .write_busy        (write_busy),
      .write_ack_timeout (write_ack_timeout),
      .overflow          (overflow),
      .drop              (drop)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int issue_cnt = 0;
   int drop_cnt = 0;
   int ovf_cnt = 0;
   int last_issue_cyc = 0;
   int mode = 3;            // 0 ack, 1 timeout, 2 ack + long busy, 3 silent
   logic [7:0] exp_q[$];

`ifdef UART_TX_QUEUE_RETRY_EN
   localparam int TO_COPIES = 3;
`else
   localparam int TO_COPIES = 1;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   initial forever begin
      @(negedge clk);
      if (rstn) begin
         if (write_enable) begin
            issue_cnt++;
            last_issue_cyc = cyc;
            check("we_while_busy", {31'd0, write_busy}, 32'd0);
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_issue: got data 0x%0h, none expected", write_data);
            end else begin
               check("issue_data", {24'd0, write_data}, {24'd0, exp_q.pop_front()});
            end
         end
         if (drop)     drop_cnt++;
         if (overflow) ovf_cnt++;
      end
   end

   // downstream responder
   initial forever begin
      @(posedge clk); #1;
      if (rstn && write_enable) begin
         case (mode)
            0: begin
               repeat (2) @(posedge clk);
               #1 write_ack = 1'b1;
               @(posedge clk); #1 write_ack = 1'b0;
            end
            1: begin
               repeat (2) @(posedge clk);
               #1 write_ack_timeout = 1'b1;
               @(posedge clk); #1 write_ack_timeout = 1'b0;
            end
            2: begin
               @(posedge clk); #1 busy_resp = 1'b1;
               @(posedge clk); #1 write_ack = 1'b1;
               @(posedge clk); #1 write_ack = 1'b0;
               repeat (4497) @(posedge clk);
               #1 busy_resp = 1'b0;
            end
            default: ;
         endcase
      end
   end

   task automatic push_byte(input logic [7:0] b, input int copies);
      push = 1'b1;
      push_data = b;
      for (int i = 0; i < copies; i++) exp_q.push_back(b);
      @(posedge clk); #1;
      push = 1'b0;
   endtask

   task automatic wait_issues(input int target, input int budget, input string name);
      int k;
      k = 0;
      while (issue_cnt < target && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      check(name, issue_cnt, target);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_empty"}, {31'd0, empty}, 32'd1);
      check({tag, "_full"},  {31'd0, full}, 32'd0);
      check({tag, "_level"}, {27'd0, level}, 32'd0);
      check({tag, "_we"},    {31'd0, write_enable}, 32'd0);
      check({tag, "_wdata"}, {24'd0, write_data}, 32'd0);
      check({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
      check({tag, "_drop"},  {31'd0, drop}, 32'd0);
   endtask

   initial begin
      int pc, base, dbase;
      #2;
      check_reset_outputs("rst");
      @(posedge clk); #1 rstn = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // single byte, ack two cycles after write_enable
      mode = 0;
      pc = cyc;
      push_byte(8'hA5, 1);
      wait_issues(1, 20, "a5_issue_cnt");
      check("a5_latency", last_issue_cyc - pc, 32'd2);
      repeat (10) @(posedge clk);
      #1;
      check("a5_empty", {31'd0, empty}, 32'd1);
      check("a5_no_drop", drop_cnt, 32'd0);

      // fill to DEPTH under back-pressure, then one overflowing push
      busy_force = 1'b1;
      for (int i = 0; i < 16; i++) push_byte(8'(i), 1);
      check("fill_full", {31'd0, full}, 32'd1);
      check("fill_level", {27'd0, level}, 32'd16);
      repeat (2) @(posedge clk);
      #1;
      check("fill_no_ovf", ovf_cnt, 32'd0);
      push_byte(8'h10, 0);
      repeat (2) @(posedge clk);
      #1;
      check("ovf_once", ovf_cnt, 32'd1);
      check("ovf_level", {27'd0, level}, 32'd16);
      check("ovf_full", {31'd0, full}, 32'd1);
      check("ovf_no_issue", issue_cnt, 32'd1);
      busy_force = 1'b0;
      wait_issues(17, 400, "drain_cnt");
      repeat (10) @(posedge clk);
      #1;
      check("drain_empty", {31'd0, empty}, 32'd1);
      check("drain_sb_empty", exp_q.size(), 32'd0);

      // ack timeout on every attempt
      mode = 1;
      base  = issue_cnt;
      dbase = drop_cnt;
      push_byte(8'h3C, TO_COPIES);
      wait_issues(base + TO_COPIES, 150, "to_issue_cnt");
      repeat (15) @(posedge clk);
      #1;
      check("to_issue_total", issue_cnt, base + TO_COPIES);
      check("to_drop_once", drop_cnt - dbase, 32'd1);
      check("to_empty", {31'd0, empty}, 32'd1);
      check("to_sb_empty", exp_q.size(), 32'd0);

      // long downstream busy after each write
      mode = 2;
      base = issue_cnt;
      push_byte(8'h11, 1);
      push_byte(8'h22, 1);
      push_byte(8'h33, 1);
      wait_issues(base + 3, 3 * 4600, "busy_issue_cnt");
      repeat (4510) @(posedge clk);
      #1;
      check("busy_empty", {31'd0, empty}, 32'd1);
      check("busy_sb_empty", exp_q.size(), 32'd0);

      // reset while waiting for an ack with bytes queued
      mode = 3;
      base = issue_cnt;
      push_byte(8'h44, 1);
      push_byte(8'h55, 1);
      push_byte(8'h66, 1);
      wait_issues(base + 1, 20, "rst_first_issue");
      repeat (3) @(posedge clk);
      #3 rstn = 1'b0;
      #1;
      check_reset_outputs("midrst");
      exp_q.delete();
      @(posedge clk); #1 rstn = 1'b1;
      base = issue_cnt;
      repeat (50) @(posedge clk);
      #1;
      check("post_rst_no_issue", issue_cnt, base);
      check("post_rst_empty", {31'd0, empty}, 32'd1);

      // queue still works after reset
      mode = 0;
      push_byte(8'h5A, 1);
      wait_issues(base + 1, 20, "post_rst_issue");
      repeat (10) @(posedge clk);
      #1;
      check("post_rst_sb_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
